// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: sequencing and hazard controller for a 5-stage MIPS pipeline.
// Drives the write enables and the flush/bubble controls of the PC, IF_ID and
// ID_EX registers. Detects load-use hazards and taken branches. Runs the program
// either continuously or one step at a time, and drains the pipeline after HALT.
//
// Ports:
//   i_clock, i_reset        rising-edge clock; asynchronous active-high reset
//   i_start, i_mode_step    start pulse (IDLE only); 0 = continuous, 1 = single-step
//   i_step                  step pulse (STEP_WAIT only)
//   i_idex_memread/_rt      load in ID_EX and its destination register
//   i_ifid_rs/_rt           source registers of the instruction in IF_ID
//   i_branch_taken          branch/jump resolved taken in ID
//   i_halt_decoded          HALT present in ID
//   o_pipe_en               clock enable for ID_EX, EX_MEM, MEM_WB
//   o_pc_we, o_ifid_we      PC / IF_ID write enables
//   o_ifid_flush            IF_ID loads a NOP on the next edge
//   o_idex_bubble           ID_EX loads zeroed control fields
//   o_state, o_done         FSM state encoding; program finished
//   o_cycle_count           active cycles since start (wraps)
//   o_stall_count           load-use stall cycles since start (saturates)
module pipeline_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_WIDTH    = 32,
  parameter int STALL_WIDTH  = 16
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic                   i_mode_step,
  input  logic                   i_step,
  input  logic                   i_idex_memread,
  input  logic [4:0]             i_idex_rt,
  input  logic [4:0]             i_ifid_rs,
  input  logic [4:0]             i_ifid_rt,
  input  logic                   i_branch_taken,
  input  logic                   i_halt_decoded,
  output logic                   o_pipe_en,
  output logic                   o_pc_we,
  output logic                   o_ifid_we,
  output logic                   o_ifid_flush,
  output logic                   o_idex_bubble,
  output logic [2:0]             o_state,
  output logic                   o_done,
  output logic [CNT_WIDTH-1:0]   o_cycle_count,
  output logic [STALL_WIDTH-1:0] o_stall_count
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RUN       = 3'd1,
    STEP_WAIT = 3'd2,
    STEP_EXEC = 3'd3,
    DRAIN     = 3'd4,
    DONE      = 3'd5
  } state_t;

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  state_t        state, state_next;
  logic [DW-1:0] drain_cnt, drain_next;
  logic          hazard;
  logic          active;

  // Register $0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign hazard = i_idex_memread && (i_idex_rt != 5'd0) &&
                  ((i_idex_rt == i_ifid_rs) || (i_idex_rt == i_ifid_rt));
  assign active = (state == RUN) || (state == STEP_EXEC);
  assign o_state = state;

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_next    = state;
    drain_next    = drain_cnt;
    o_pipe_en     = 1'b0;
    o_pc_we       = 1'b0;
    o_ifid_we     = 1'b0;
    o_ifid_flush  = 1'b0;
    o_idex_bubble = 1'b0;
    o_done        = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) state_next = i_mode_step ? STEP_WAIT : RUN;
      end
      RUN, STEP_EXEC: begin
        o_pipe_en = 1'b1;
        // A single step always returns to STEP_WAIT unless HALT is accepted.
        if (state == STEP_EXEC) state_next = STEP_WAIT;
        if (hazard) begin
          // Stall outranks branch and HALT; both are re-evaluated on the next active cycle.
          o_idex_bubble = 1'b1;
        end else if (i_halt_decoded) begin
          o_idex_bubble = 1'b1;
          state_next    = DRAIN;
          drain_next    = DW'(DRAIN_CYCLES);
        end else begin
          o_pc_we      = 1'b1;
          o_ifid_we    = 1'b1;
          o_ifid_flush = i_branch_taken;
        end
      end
      STEP_WAIT: begin
        if (i_step) state_next = STEP_EXEC;
      end
      DRAIN: begin
        o_pipe_en     = 1'b1;
        o_idex_bubble = 1'b1;
        drain_next    = drain_cnt - 1'b1;
        if (drain_cnt == DW'(1)) state_next = DONE;
      end
      DONE: begin
        o_done = 1'b1;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state         <= IDLE;
      drain_cnt     <= '0;
      o_cycle_count <= '0;
      o_stall_count <= '0;
    end else begin
      state     <= state_next;
      drain_cnt <= drain_next;
      if (state == IDLE && i_start) begin
        o_cycle_count <= '0;
        o_stall_count <= '0;
      end else begin
        if (o_pipe_en) o_cycle_count <= o_cycle_count + 1'b1;
        if (active && hazard && (o_stall_count != {STALL_WIDTH{1'b1}}))
          o_stall_count <= o_stall_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl. Random and directed stimulus is
// compared against a cycle-level reference model written from the controller's
// behavioural rules.
module tb_pipeline_ctrl;

  typedef struct packed {
    logic       start;
    logic       mode;
    logic       step;
    logic       mr;
    logic [4:0] idrt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       br;
    logic       halt;
  } stim_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, mode_step = 1'b0, step = 1'b0;
  logic        idex_memread = 1'b0, branch_taken = 1'b0, halt_decoded = 1'b0;
  logic [4:0]  idex_rt = '0, ifid_rs = '0, ifid_rt = '0;
  logic        pipe_en, pc_we, ifid_we, ifid_flush, idex_bubble, done;
  logic [2:0]  state;
  logic [31:0] cycle_count;
  logic [15:0] stall_count;

  int total = 0;
  int bad   = 0;

  // Reference model: phase 0..5 = idle, run, step-wait, step-exec, drain, done.
  int        m_phase = 0;
  int        m_drain = 0;
  int        m_stall = 0;
  bit [31:0] m_cyc   = '0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.DRAIN_CYCLES(3), .CNT_WIDTH(32), .STALL_WIDTH(16)) dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_start        (start),
    .i_mode_step    (mode_step),
    .i_step         (step),
    .i_idex_memread (idex_memread),
    .i_idex_rt      (idex_rt),
    .i_ifid_rs      (ifid_rs),
    .i_ifid_rt      (ifid_rt),
    .i_branch_taken (branch_taken),
    .i_halt_decoded (halt_decoded),
    .o_pipe_en      (pipe_en),
    .o_pc_we        (pc_we),
    .o_ifid_we      (ifid_we),
    .o_ifid_flush   (ifid_flush),
    .o_idex_bubble  (idex_bubble),
    .o_state        (state),
    .o_done         (done),
    .o_cycle_count  (cycle_count),
    .o_stall_count  (stall_count)
  );

  function automatic stim_t rnd_stim(input int halt_pct);
    stim_t s;
    s.start = 1'($urandom_range(1));
    s.mode  = 1'($urandom_range(1));
    s.step  = 1'($urandom_range(1));
    s.mr    = 1'($urandom_range(1));
    s.idrt  = 5'($urandom_range(3));
    s.rs    = 5'($urandom_range(3));
    s.rt    = 5'($urandom_range(3));
    s.br    = 1'($urandom_range(1));
    s.halt  = 1'($urandom_range(99) < halt_pct);
    return s;
  endfunction

  // Expected {pipe_en, pc_we, ifid_we, flush, bubble} for the current phase.
  function automatic logic [4:0] exp_ctl(input stim_t s, input bit hz);
    if (m_phase == 1 || m_phase == 3) begin
      if (hz || s.halt) return 5'b10001;
      if (s.br)         return 5'b11110;
      return 5'b11100;
    end
    if (m_phase == 4) return 5'b10001;
    return 5'b00000;
  endfunction

  // One clock: drive after the falling edge, compare, then advance the model.
  task automatic apply(input stim_t s, input bit chk, output bit pe);
    bit         hz;
    logic [4:0] want;
    @(negedge clk);
    start = s.start; mode_step = s.mode; step = s.step;
    idex_memread = s.mr; idex_rt = s.idrt; ifid_rs = s.rs; ifid_rt = s.rt;
    branch_taken = s.br; halt_decoded = s.halt;
    #1;
    pe   = pipe_en;
    hz   = s.mr && s.idrt != 0 && (s.idrt == s.rs || s.idrt == s.rt);
    want = exp_ctl(s, hz);
    if (chk) begin
      total++;
      if ({pipe_en, pc_we, ifid_we, ifid_flush, idex_bubble} !== want) begin
        bad++;
        $display("FAIL ctl phase=%0d got=%b want=%b", m_phase,
                 {pipe_en, pc_we, ifid_we, ifid_flush, idex_bubble}, want);
      end
      total++;
      if (state !== 3'(m_phase)) begin
        bad++; $display("FAIL state got=%0d want=%0d", state, m_phase);
      end
      total++;
      if (done !== (m_phase == 5)) begin
        bad++; $display("FAIL done got=%b want=%b", done, m_phase == 5);
      end
      total++;
      if (cycle_count !== m_cyc) begin
        bad++; $display("FAIL cycle_count got=%0d want=%0d", cycle_count, m_cyc);
      end
      total++;
      if (stall_count !== 16'(m_stall)) begin
        bad++; $display("FAIL stall_count got=%0d want=%0d", stall_count, m_stall);
      end
    end
    case (m_phase)
      0: if (s.start) begin
           m_cyc = 0; m_stall = 0; m_phase = s.mode ? 2 : 1;
         end
      1, 3: begin
        m_cyc++;
        if (hz) begin
          if (m_stall < 65535) m_stall++;
          m_phase = (m_phase == 3) ? 2 : 1;
        end else if (s.halt) begin
          m_phase = 4; m_drain = 3;
        end else begin
          m_phase = (m_phase == 3) ? 2 : 1;
        end
      end
      2: if (s.step) m_phase = 3;
      4: begin
        m_cyc++;
        if (m_drain == 1) m_phase = 5;
        m_drain--;
      end
      default: ;
    endcase
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    start = 0; mode_step = 0; step = 0; idex_memread = 0; idex_rt = 0;
    ifid_rs = 0; ifid_rt = 0; branch_taken = 0; halt_decoded = 0;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({pipe_en, pc_we, ifid_we, ifid_flush, idex_bubble, done} !== 6'b0) begin
      bad++; $display("FAIL reset_ctl got=%b want=000000",
                      {pipe_en, pc_we, ifid_we, ifid_flush, idex_bubble, done});
    end
    total++;
    if (state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
    total++;
    if (cycle_count !== 32'd0 || stall_count !== 16'd0) begin
      bad++; $display("FAIL reset_counts got=%0d/%0d want=0/0", cycle_count, stall_count);
    end
    m_phase = 0; m_cyc = 0; m_stall = 0; m_drain = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic stim_t go(input bit mode);
    stim_t s = '0;
    s.start = 1'b1; s.mode = mode;
    return s;
  endfunction

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_load_use();
    stim_t s;
    bit    pe;
    do_reset();
    apply(go(1'b0), 1'b1, pe);
    s = '0; s.mr = 1; s.idrt = 5; s.rs = 5; s.rt = 9;
    apply(s, 1'b1, pe);
    #1;
    total++;
    if (stall_count !== 16'd1) begin
      bad++; $display("FAIL load_use_stall got=%0d want=1", stall_count);
    end
    s.idrt = 0; s.rs = 0;
    apply(s, 1'b1, pe);
    s = '0; s.mr = 1; s.idrt = 7; s.rt = 7;
    apply(s, 1'b1, pe);
    for (int i = 0; i < 60; i++) apply(rnd_stim(0), 1'b1, pe);
  endtask

  task automatic test_branch();
    stim_t s;
    bit    pe;
    do_reset();
    apply(go(1'b0), 1'b1, pe);
    s = '0; s.br = 1;
    apply(s, 1'b1, pe);
    s.mr = 1; s.idrt = 3; s.rt = 3;
    apply(s, 1'b1, pe);
    s = '0;
    apply(s, 1'b1, pe);
  endtask

  task automatic test_halt();
    stim_t s;
    bit    pe;
    do_reset();
    apply(go(1'b0), 1'b1, pe);
    s = '0;
    for (int i = 0; i < 5; i++) apply(s, 1'b1, pe);
    s.halt = 1; s.br = 1;
    apply(s, 1'b1, pe);
    s = '0;
    for (int i = 0; i < 3; i++) apply(s, 1'b1, pe);
    #1;
    total++;
    if (cycle_count !== 32'd9 || done !== 1'b1 || state !== 3'd5) begin
      bad++; $display("FAIL halt_drain got=cyc%0d done%b st%0d want=cyc9 done1 st5",
                      cycle_count, done, state);
    end
    apply(go(1'b0), 1'b1, pe);
    s = '0; s.step = 1;
    apply(s, 1'b1, pe);
    apply(go(1'b1), 1'b1, pe);
  endtask

  task automatic test_step();
    stim_t s;
    bit    pe;
    int    pulses;
    do_reset();
    apply(go(1'b1), 1'b1, pe);
    s = '0;
    for (int i = 0; i < 4; i++) apply(s, 1'b1, pe);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      s.step = 1; apply(s, 1'b1, pe); pulses += int'(pe);
      s.step = 0; apply(s, 1'b1, pe); pulses += int'(pe);
      apply(s, 1'b1, pe);             pulses += int'(pe);
    end
    #1;
    total++;
    if (pulses != 3 || cycle_count !== 32'd3) begin
      bad++; $display("FAIL step_pulses got=%0d cyc=%0d want=3 cyc=3", pulses, cycle_count);
    end
    s = '0; s.step = 1;
    for (int i = 0; i < 6; i++) apply(s, 1'b1, pe);
    // Stall during a step consumes it.
    s.mr = 1; s.idrt = 4; s.rs = 4;
    for (int i = 0; i < 3; i++) apply(s, 1'b1, pe);
    for (int i = 0; i < 80; i++) apply(rnd_stim(4), 1'b1, pe);
  endtask

  task automatic test_reset_mid_run();
    stim_t s;
    bit    pe;
    do_reset();
    apply(go(1'b0), 1'b1, pe);
    for (int i = 0; i < 20; i++) apply(rnd_stim(0), 1'b1, pe);
    s = '0; s.mr = 1; s.idrt = 2; s.rt = 2;
    apply(s, 1'b1, pe);
    do_reset();
  endtask

  task automatic test_random();
    bit pe;
    for (int r = 0; r < 6; r++) begin
      do_reset();
      apply(go(1'($urandom_range(1))), 1'b1, pe);
      for (int i = 0; i < 150 && m_phase != 5; i++) apply(rnd_stim(3), 1'b1, pe);
      for (int i = 0; i < 2; i++) apply(rnd_stim(3), 1'b1, pe);
    end
  endtask

  task automatic test_saturation();
    stim_t s;
    bit    pe;
    do_reset();
    apply(go(1'b0), 1'b1, pe);
    s = '0; s.mr = 1; s.idrt = 6; s.rs = 6;
    for (int i = 0; i < 70000; i++) apply(s, 1'b0, pe);
    apply(s, 1'b1, pe);
    #1;
    total++;
    if (stall_count !== 16'hFFFF) begin
      bad++; $display("FAIL stall_saturate got=%0d want=65535", stall_count);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_halt();
    test_step();
    test_reset_mid_run();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Sequencing and hazard controller for the 5-stage MIPS pipeline.
- Drives write enables and flush/bubble controls of the PC, IF_ID and ID_EX registers.
- Detects load-use hazards and taken-branch flushes, runs the program in continuous or single-step (debug) mode, and drains the pipeline after HALT.
- Reports run statistics.

Parameters:
- DRAIN_CYCLES, 3, cycles spent in DRAIN after HALT is decoded (≥1); covers EX/MEM/WB retirement.
- CNT_WIDTH, 32, width of o_cycle_count.
- STALL_WIDTH, 16, width of o_stall_count.

Ports:
- i_clock  in  1  single system clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_start  in  1  start pulse; honoured only in IDLE.
- i_mode_step  in  1  0 = continuous, 1 = single-step; sampled only when i_start is accepted.
- i_step  in  1  step pulse; honoured only in STEP_WAIT.
- i_idex_memread  in  1  instruction in ID_EX is a load.
- i_idex_rt  in  5  destination rt of the instruction in ID_EX.
- i_ifid_rs  in  5  rs of the instruction in IF_ID.
- i_ifid_rt  in  5  rt of the instruction in IF_ID.
- i_branch_taken  in  1  branch/jump resolved taken in ID.
- i_halt_decoded  in  1  HALT opcode present in ID.
- o_pipe_en  out  1  global clock enable for ID_EX, EX_MEM, MEM_WB.
- o_pc_we  out  1  PC write enable.
- o_ifid_we  out  1  IF_ID write enable.
- o_ifid_flush  out  1  IF_ID loads NOP on next edge.
- o_idex_bubble  out  1  ID_EX loads zero ex/mem/wb control fields.
- o_state  out  3  current FSM state encoding.
- o_done  out  1  program finished.
- o_cycle_count  out  CNT_WIDTH  active cycles since start.
- o_stall_count  out  STALL_WIDTH  load-use stall cycles since start.

Behaviour:
- FSM states: IDLE=0, RUN=1, STEP_WAIT=2, STEP_EXEC=3, DRAIN=4, DONE=5.
- Reset (async, any time including mid-run): state goes to IDLE immediately.
  - Drain counter and both statistic counters are cleared.
  - All control outputs are 0; o_done=0.
- IDLE: all controls 0.
  - i_start=1 clears both counters and moves to RUN if i_mode_step=0, otherwise to STEP_WAIT.
- Active cycle (RUN or STEP_EXEC): o_pipe_en=1. Controls are combinational from state and inputs, with this priority:
  1. Load-use hazard: i_idex_memread && i_idex_rt!=0 && (i_idex_rt==i_ifid_rs || i_idex_rt==i_ifid_rt).
     - o_pc_we=0, o_ifid_we=0, o_idex_bubble=1, o_ifid_flush=0.
     - Branch and HALT are ignored this cycle and re-evaluated on the next active cycle.
     - o_stall_count increments, saturating at all-ones.
  2. i_halt_decoded: o_pc_we=0, o_ifid_we=0, o_idex_bubble=1.
     - Next state is DRAIN; drain counter loads DRAIN_CYCLES.
     - HALT wins over a simultaneous i_branch_taken.
  3. i_branch_taken: o_pc_we=1, o_ifid_we=1, o_ifid_flush=1, o_idex_bubble=0.
  4. Otherwise: o_pc_we=1, o_ifid_we=1, flush=0, bubble=0.
- RUN: remains in RUN until HALT is accepted.
- STEP_EXEC: lasts exactly one cycle, then returns to STEP_WAIT, or goes to DRAIN if HALT is accepted.
  - A load-use stall consumes the step; the stalled instruction advances on the next step.
- STEP_WAIT: all controls 0 (pipeline frozen). i_step=1 moves to STEP_EXEC on the next edge.
- DRAIN: runs freely regardless of step mode.
  - o_pipe_en=1, o_pc_we=0, o_ifid_we=0, o_idex_bubble=1, o_ifid_flush=0.
  - Counter decrements each cycle; when counter==1, next state is DONE.
  - DRAIN therefore lasts exactly DRAIN_CYCLES cycles.
- DONE: all controls 0, o_done=1. i_start and i_step are ignored; only reset leaves DONE.
- o_cycle_count: +1 on every cycle with o_pipe_en=1 (RUN, STEP_EXEC, DRAIN); wraps modulo 2^CNT_WIDTH.
- Counters and state update on the rising edge. Control outputs are same-cycle combinational (zero latency), so stalls take effect on the edge that ends the hazard cycle.
- i_step held high: one STEP_EXEC per STEP_WAIT visit, i.e. one active cycle every 2 clocks.

Test Plan:
- Reset mid-RUN with the counters nonzero → o_state=0, all controls 0, counters=0 without waiting for a clock edge.
- Continuous mode, i_start; load in ID_EX with rt=5, IF_ID rs=5 for one cycle → that cycle pc_we=0, ifid_we=0, bubble=1; o_stall_count=1. Repeat with rt=0 → no stall.
- RUN with i_branch_taken=1 for one cycle → pc_we=1, ifid_we=1, ifid_flush=1, bubble=0. Same cycle with load-use also true → stall outputs only, flush=0.
- RUN, assert i_halt_decoded together with i_branch_taken → bubble=1, pc_we=0. State: DRAIN for exactly 3 cycles, then DONE with o_done=1; o_cycle_count = run cycles + 3. A later i_start is ignored.
- Step mode: i_start, then 4 cycles idle → o_pipe_en=0 and o_cycle_count static. Three i_step pulses → exactly 3 single-cycle o_pipe_en pulses; o_cycle_count=3.
- Load-use condition held for 70000 active cycles → o_stall_count saturates at 65535 and does not wrap.
